tx_queue_scheduler: RTL
=======================

# tx_queue_scheduler

Transmit-side counterpart to the receive flow director: the receive path steers packets into host queues, while this block drains host TX queues toward the Ethernet path. It accepts doorbell requests announcing how many packets a TX queue has pending and keeps a saturating pending count per queue. It arbitrates round-robin among queues with pending work and emits one metadata beat per packet, tagged with its queue id, over a valid/ready interface to the TX packet fetch logic.

## Interface
- NB_QUEUES, 16: number of TX queues; power of two, at least 2.
- CNT_W, 16: width of each per-queue pending counter.
- QID_W, $clog2(NB_QUEUES): queue id width (derived, not overridden).
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- in_req_queue_id  in  QID_W  doorbell target queue.
- in_req_nb_pkts  in  CNT_W  packets added by this doorbell; 0 is legal and a no-op.
- in_req_valid  in  1  doorbell valid.
- in_req_ready  out  1  doorbell ready.
- out_meta_data  out  metadata_t  emitted packet metadata.
- out_meta_valid  out  1  metadata valid.
- out_meta_ready  in  1  downstream ready.
- nb_active_queues  in  32  configuration: number of enabled queues.
- bad_req_cnt  out  32  doorbells discarded because they targeted a disabled queue.
- sat_cnt  out  32  doorbells whose add saturated a pending counter.

## Operation
- A doorbell is accepted when in_req_valid && in_req_ready. in_req_ready is 0 during reset and 1 from the first clock edge after rst_n deasserts.
- Effective enabled count eff_nb = min(nb_active_queues, NB_QUEUES).
- Accepted doorbell with in_req_queue_id >= eff_nb: discarded, and bad_req_cnt increments.
- Otherwise, pending[q] += nb_pkts, saturating at 2^CNT_W-1. If the sum overflows, sat_cnt increments once for that doorbell.
- Eligible queue: pending[q] != 0 and q < eff_nb.
- Arbitration:
  - Select the first eligible queue strictly after last_grant, wrapping modulo NB_QUEUES.
  - last_grant resets to NB_QUEUES-1, so queue 0 wins first.
  - last_grant updates only when a beat is loaded.
- The output register loads when (!out_meta_valid || out_meta_ready) and an eligible queue exists. On load:
  - out_meta_data: all fields 0, except pkt_queue_id = selected queue (zero-extended) and pkt_flags = PKT_ETH.
  - pending[selected] decrements by 1.
- If the load condition holds and no queue is eligible, out_meta_valid falls to 0.
- Doorbell to the queue being decremented in the same cycle: pending = sat(pending + nb_pkts) - 1. A doorbell for a queue that is not being granted does not interact with the grant.
- Lowering nb_active_queues: queues at or above eff_nb are no longer arbitrated, but their counts are retained. Raising it back resumes them. A beat already in the output register is unaffected.
- nb_active_queues == 0: nothing is emitted and every doorbell is counted in bad_req_cnt.
- bad_req_cnt and sat_cnt wrap at 2^32.

## Timing
- Reset values: out_meta_valid 0, out_meta_data 0, in_req_ready 0, all pending 0, last_grant NB_QUEUES-1, bad_req_cnt 0, sat_cnt 0.
- Latency: a doorbell accepted at edge k updates pending at k. Arbitration is combinational on the registered pending values, so the beat loads at edge k+1 and out_meta_valid is high in the cycle after edge k+1.
- Throughput: one beat per cycle while out_meta_ready stays 1 and work is eligible.
- Valid/ready rules:
  - out_meta_data is stable while out_meta_valid && !out_meta_ready.
  - out_meta_valid never drops without a handshake.
  - out_meta_valid does not depend combinationally on out_meta_ready.
- in_req_ready has no combinational dependence on out_meta_ready.
- rst_n assertion mid-operation clears all state immediately, including any unconsumed output beat, whose packet is lost.

## Structure
- metadata_t, PKT_ETH and PKT_PCIE belong to the shared constants package. Add PKT_ETH there if it is not already defined. No local typedefs.
- Sub-module rr_arbiter (parameter N): inputs are the request vector and last_grant, outputs are grant index and grant_valid. It is purely combinational and reusable by the RX-side queue logic.
- Counters and the output register stay in tx_queue_scheduler.

## Test plan
- Reset, then a doorbell (q=3, n=2) with out_meta_ready=1 -> two beats with pkt_queue_id 3 and pkt_flags PKT_ETH, starting two cycles after acceptance. pending[3] ends at 0.
- Doorbells q0 n=2, q1 n=1, q2 n=2 → beat order 0,1,2,0,2 on consecutive cycles.
- out_meta_ready held 0 for 5 cycles with a beat valid -> data held constant and no pending decrement. Release -> beats resume with no loss and no duplication.
- nb_active_queues=4, doorbell q=6 n=3 -> bad_req_cnt=1 and no beats. Set nb_active_queues=0 while q1 has pending=2 -> emission stops. Restore to 4 -> two beats for q1.
- Doorbell q5 n=0xFFFF, then q5 n=1 → sat_cnt=1 and pending[5]=0xFFFF. A doorbell to the queue in the same cycle as its grant yields pending = old + n - 1.
- Assert rst_n mid-stream with out_meta_valid=1 -> all outputs return to their reset values asynchronously, and no beats follow without new doorbells.

Source files
------------

// File: rtl/tx_queue_scheduler_pkg.sv
// Shared constants for the host queue datapath.
// Holds the packet metadata beat layout and the packet flag encodings used by
// both the RX flow director and the TX queue scheduler.
package tx_queue_scheduler_pkg;

   // Packet origin flags carried in metadata_t.pkt_flags
   localparam logic [7:0] PKT_ETH  = 8'h01;
   localparam logic [7:0] PKT_PCIE = 8'h02;

   // One metadata beat per packet
   typedef struct packed {
      logic [31:0] pkt_hash;
      logic [15:0] pkt_len;
      logic [15:0] pkt_queue_id;
      logic [7:0]  pkt_flags;
   } metadata_t;

endpackage

// File: rtl/tx_queue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request strictly after last_grant_i, wrapping modulo N.
// Ports:
//   req_i         request vector, one bit per requester
//   last_grant_i  index of the previous winner
//   grant_o       index of the selected requester (0 when none)
//   grant_valid_o at least one request is asserted
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_grant_i,
   output logic [IDX_W-1:0] grant_o,
   output logic             grant_valid_o
);

   int unsigned idx;

   always_comb begin
      grant_o       = '0;
      grant_valid_o = 1'b0;
      idx           = 0;
      // Offset 1..N from the last winner; offset N revisits last_grant_i itself
      for (int unsigned i = 1; i <= N; i++) begin
         idx = (32'(last_grant_i) + i) % N;
         if (!grant_valid_o && req_i[IDX_W'(idx)]) begin
            grant_o       = IDX_W'(idx);
            grant_valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_queue_scheduler.sv
// TX queue scheduler.
// Collects doorbells announcing pending packets per host TX queue, keeps a
// saturating pending count per queue and emits one metadata beat per packet,
// round-robin across enabled queues with pending work.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_req_*                   doorbell (queue id, packet count) valid/ready
//   out_meta_*                 metadata beat valid/ready toward TX fetch
//   nb_active_queues           number of enabled queues (clamped to NB_QUEUES)
//   bad_req_cnt                doorbells dropped for targeting a disabled queue
//   sat_cnt                    doorbells whose add saturated a pending counter
module tx_queue_scheduler
   import tx_queue_scheduler_pkg::*;
#(
   parameter int unsigned NB_QUEUES = 16,
   parameter int unsigned CNT_W     = 16,
   localparam int unsigned QID_W    = $clog2(NB_QUEUES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [QID_W-1:0] in_req_queue_id,
   input  logic [CNT_W-1:0] in_req_nb_pkts,
   input  logic             in_req_valid,
   output logic             in_req_ready,
   output metadata_t        out_meta_data,
   output logic             out_meta_valid,
   input  logic             out_meta_ready,
   input  logic [31:0]      nb_active_queues,
   output logic [31:0]      bad_req_cnt,
   output logic [31:0]      sat_cnt
);

   logic                            ready_q;
   logic                            valid_q, valid_d;
   metadata_t                       data_q, data_d;
   logic [NB_QUEUES-1:0][CNT_W-1:0] pending_q, pending_d;
   logic [QID_W-1:0]                last_grant_q, last_grant_d;
   logic [31:0]                     bad_q, bad_d;
   logic [31:0]                     sat_q, sat_d;

   logic [31:0]          eff_nb;
   logic [NB_QUEUES-1:0] eligible;
   logic [QID_W-1:0]     grant;
   logic                 grant_valid;
   logic                 req_acc;
   logic                 req_in_range;
   logic                 advance;
   logic                 load;
   logic [CNT_W:0]       add_sum;

   assign eff_nb = (nb_active_queues > 32'(NB_QUEUES)) ? 32'(NB_QUEUES) : nb_active_queues;

   always_comb begin
      eligible = '0;
      for (int unsigned q = 0; q < NB_QUEUES; q++) begin
         eligible[q] = (pending_q[q] != '0) && (q < eff_nb);
      end
   end

   rr_arbiter #(
      .N (NB_QUEUES)
   ) u_rr_arbiter (
      .req_i         (eligible),
      .last_grant_i  (last_grant_q),
      .grant_o       (grant),
      .grant_valid_o (grant_valid)
   );

   assign req_acc      = in_req_valid && ready_q;
   assign req_in_range = 32'(in_req_queue_id) < eff_nb;
   // Output slot is free or being drained this cycle
   assign advance      = !valid_q || out_meta_ready;
   assign load         = advance && grant_valid;
   // One extra bit to detect counter overflow
   assign add_sum      = {1'b0, pending_q[in_req_queue_id]} + {1'b0, in_req_nb_pkts};

   always_comb begin
      pending_d    = pending_q;
      bad_d        = bad_q;
      sat_d        = sat_q;
      valid_d      = valid_q;
      data_d       = data_q;
      last_grant_d = last_grant_q;

      if (req_acc && !req_in_range) begin
         bad_d = bad_q + 32'd1;
      end

      if (req_acc && req_in_range) begin
         if (add_sum[CNT_W]) begin
            pending_d[in_req_queue_id] = '1;
            sat_d                      = sat_q + 32'd1;
         end else begin
            pending_d[in_req_queue_id] = add_sum[CNT_W-1:0];
         end
      end

      if (advance) begin
         valid_d = grant_valid;
      end

      // Decrement applies after the doorbell add so a same-cycle doorbell
      // to the granted queue yields sat(old + n) - 1
      if (load) begin
         data_d              = '0;
         data_d.pkt_queue_id = 16'(grant);
         data_d.pkt_flags    = PKT_ETH;
         last_grant_d        = grant;
         pending_d[grant]    = pending_d[grant] - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q      <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         pending_q    <= '0;
         last_grant_q <= QID_W'(NB_QUEUES - 1);
         bad_q        <= '0;
         sat_q        <= '0;
      end else begin
         ready_q      <= 1'b1;
         valid_q      <= valid_d;
         data_q       <= data_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         bad_q        <= bad_d;
         sat_q        <= sat_d;
      end
   end

   assign in_req_ready   = ready_q;
   assign out_meta_valid = valid_q;
   assign out_meta_data  = data_q;
   assign bad_req_cnt    = bad_q;
   assign sat_cnt        = sat_q;

endmodule
